// File: rtl/branch_resolve_predict.sv
// ---------------------------------------------------------------------------
// branch_resolve_predict
//   Branch unit placed between the fetch PC mux and the EX stage.
//   - Fetch side: combinational lookup of a direct-mapped BTB with 2-bit BHT
//     counters. It predicts taken when the entry hits and counter[1] is set.
//   - EX side: resolves conditional branches, JAL and JALR. It compares the
//     outcome with the prediction carried from fetch and issues a registered
//     one-cycle redirect on mispredict. It flags misaligned taken targets and
//     trains the table. It also counts resolved transfers and mispredicts.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   f_pc                          fetch PC to look up
//   f_pred_taken, f_pred_target   fetch prediction (target 0 on miss)
//   ex_valid, ex_stall            EX holds a transfer / EX frozen this cycle
//   ex_br, ex_jal, ex_jalr        instruction class (one-hot when ex_valid)
//   ex_funct3                     branch condition
//   ex_pc, ex_rs1, ex_rs2         instruction PC and operands
//   ex_imm_b, ex_imm_j, ex_imm_i  sign-extended immediates
//   ex_pred_taken, ex_pred_target prediction made at fetch
//   redirect_valid, redirect_pc   one-cycle refetch request
//   exc_misaligned, exc_tval      one-cycle misaligned-target exception
//   br_count, mp_count            wrapping event counters
// ---------------------------------------------------------------------------
module branch_resolve_predict #(
    parameter int              XLEN          = 32,
    parameter int              PC_STEP       = 1,
    parameter int              ENTRIES       = 16,
    parameter int              IDX_LSB       = 0,
    parameter logic [XLEN-1:0] MISALIGN_MASK = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_br,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm_b,
    input  logic [XLEN-1:0] ex_imm_j,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            exc_misaligned,
    output logic [XLEN-1:0] exc_tval,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IDX_LSB - IW;

    // Table state
    logic [ENTRIES-1:0] btb_valid;
    logic [TW-1:0]      btb_tag    [ENTRIES];
    logic [XLEN-1:0]    btb_target [ENTRIES];
    logic [1:0]         bht_ctr    [ENTRIES];

    // Fetch-side lookup reads only registered state. A same-cycle EX update is
    // therefore not visible until the next cycle.
    logic [IW-1:0] f_idx;
    logic [TW-1:0] f_tag;
    logic          f_hit;

    assign f_idx         = f_pc[IDX_LSB +: IW];
    assign f_tag         = f_pc[XLEN-1 -: TW];
    assign f_hit         = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_pred_taken  = f_hit && bht_ctr[f_idx][1];
    assign f_pred_target = f_hit ? btb_target[f_idx] : '0;

    // EX-side resolution
    logic            cond_true;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            resolve;
    logic            misaligned;
    logic            mispredict;
    logic [IW-1:0]   ex_idx;
    logic [TW-1:0]   ex_tag;
    logic            ex_hit;
    logic [1:0]      ctr_cur;
    logic [1:0]      ctr_next;
    logic            ctr_write;
    logic            btb_write;

    // NOTE: every always_comb output gets a default first. A path that leaves
    // a signal unassigned would otherwise infer a latch.
    always_comb begin
        cond_true = 1'b0;
        case (ex_funct3)
            3'b000:  cond_true = (ex_rs1 == ex_rs2);
            3'b001:  cond_true = (ex_rs1 != ex_rs2);
            3'b100:  cond_true = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond_true = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond_true = (ex_rs1 <  ex_rs2);
            3'b111:  cond_true = (ex_rs1 >= ex_rs2);
            default: cond_true = 1'b0;
        endcase
    end

    assign taken   = ex_jal | ex_jalr | (ex_br & cond_true);
    // JALR clears bit 0 of its computed target.
    assign target  = ex_jalr ? ((ex_rs1 + ex_imm_i) & {{(XLEN-1){1'b1}}, 1'b0})
                   : ex_jal  ? (ex_pc + ex_imm_j)
                   :           (ex_pc + ex_imm_b);
    assign next_pc = taken ? target : ex_pc + XLEN'(PC_STEP);

    assign resolve    = ex_valid & ~ex_stall;
    assign misaligned = taken && ((target & MISALIGN_MASK) != '0);
    assign mispredict = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));

    assign ex_idx  = ex_pc[IDX_LSB +: IW];
    assign ex_tag  = ex_pc[XLEN-1 -: TW];
    assign ex_hit  = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign ctr_cur = bht_ctr[ex_idx];

    // Training: branches move the counter, JAL pins it to strongly-taken.
    // A taken branch that misses the tag allocates a fresh weakly-taken entry.
    // JALR targets are register-dependent, so JALR never trains the table.
    always_comb begin
        ctr_next = ctr_cur;
        if (ex_jal) begin
            ctr_next = 2'b11;
        end else if (ex_br && taken) begin
            if (!ex_hit)               ctr_next = 2'b10;
            else if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else if (ex_br) begin
            if (ctr_cur != 2'b00)      ctr_next = ctr_cur - 2'd1;
        end
    end

    assign ctr_write = resolve & ~misaligned & (ex_br | ex_jal);
    assign btb_write = resolve & ~misaligned & ((ex_br & taken) | ex_jal);

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values, whatever the order of the blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            exc_misaligned <= 1'b0;
            exc_tval       <= '0;
            br_count       <= '0;
            mp_count       <= '0;
            btb_valid      <= '0;
            for (int i = 0; i < ENTRIES; i++) bht_ctr[i] <= 2'b01;
        end else begin
            redirect_valid <= 1'b0;
            exc_misaligned <= 1'b0;
            if (resolve) begin
                br_count <= br_count + 32'd1;
                if (misaligned) begin
                    exc_misaligned <= 1'b1;
                    exc_tval       <= target;
                end else if (mispredict) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= next_pc;
                    mp_count       <= mp_count + 32'd1;
                end
            end
            if (ctr_write) bht_ctr[ex_idx]   <= ctr_next;
            if (btb_write) btb_valid[ex_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target storage is not reset. The cleared valid bits already
    // mask stale contents, so the storage can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && btb_write) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= target;
        end
    end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_predict
//   Two instances share all inputs: u_dut0 has no alignment mask and u_dut3
//   has mask 3. A behavioural table model tracks both instances. It predicts
//   each fetch lookup and each registered EX result.
// ---------------------------------------------------------------------------
module tb_branch_resolve_predict;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        ex_valid, ex_stall, ex_br, ex_jal, ex_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm_b, ex_imm_j, ex_imm_i;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        pt   [2];
    logic [31:0] ptg  [2];
    logic        rv   [2];
    logic [31:0] rpc  [2];
    logic        exc  [2];
    logic [31:0] tval [2];
    logic [31:0] brc  [2];
    logic [31:0] mpc  [2];

    int errors = 0;
    int checks = 0;

    // Reference model state, indexed [dut][entry]
    bit          m_valid [2][16];
    logic [27:0] m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_ctr   [2][16];
    logic        e_rv   [2];
    logic [31:0] e_rpc  [2];
    logic        e_exc  [2];
    logic [31:0] e_tval [2];
    logic [31:0] e_br   [2];
    logic [31:0] e_mp   [2];

    always #5 clk = ~clk;

    branch_resolve_predict #(.XLEN(32), .PC_STEP(1), .ENTRIES(16), .IDX_LSB(0),
                             .MISALIGN_MASK(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .f_pc(f_pc),
        .f_pred_taken(pt[0]), .f_pred_target(ptg[0]),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_br(ex_br), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_imm_b(ex_imm_b), .ex_imm_j(ex_imm_j), .ex_imm_i(ex_imm_i),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
        .exc_misaligned(exc[0]), .exc_tval(tval[0]),
        .br_count(brc[0]), .mp_count(mpc[0]));

    branch_resolve_predict #(.XLEN(32), .PC_STEP(1), .ENTRIES(16), .IDX_LSB(0),
                             .MISALIGN_MASK(32'h3)) u_dut3 (
        .clk(clk), .reset(reset), .f_pc(f_pc),
        .f_pred_taken(pt[1]), .f_pred_target(ptg[1]),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_br(ex_br), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_imm_b(ex_imm_b), .ex_imm_j(ex_imm_j), .ex_imm_i(ex_imm_i),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
        .exc_misaligned(exc[1]), .exc_tval(tval[1]),
        .br_count(brc[1]), .mp_count(mpc[1]));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Applies the architectural rules for one clock edge to both model copies.
    task automatic model_clock();
        bit          cond, tk, hit;
        logic [31:0] tgt, mask;
        int          idx;
        logic [27:0] tg;
        case (ex_funct3)
            3'd0:    cond = (ex_rs1 == ex_rs2);
            3'd1:    cond = (ex_rs1 != ex_rs2);
            3'd4:    cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'd5:    cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'd6:    cond = (ex_rs1 <  ex_rs2);
            3'd7:    cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
        tk = ex_jal || ex_jalr || (ex_br && cond);
        if (ex_jalr)     tgt = (ex_rs1 + ex_imm_i) - ((ex_rs1 + ex_imm_i) % 2);
        else if (ex_jal) tgt = ex_pc + ex_imm_j;
        else             tgt = ex_pc + ex_imm_b;
        idx = int'(ex_pc % 16);
        tg  = 28'(ex_pc / 16);
        for (int d = 0; d < 2; d++) begin
            mask = (d == 1) ? 32'd3 : 32'd0;
            if (reset) begin
                e_rv[d] = 0; e_rpc[d] = 0; e_exc[d] = 0; e_tval[d] = 0;
                e_br[d] = 0; e_mp[d] = 0;
                for (int i = 0; i < 16; i++) begin
                    m_valid[d][i] = 0;
                    m_ctr[d][i]   = 1;
                end
            end else begin
                e_rv[d]  = 0;
                e_exc[d] = 0;
                if (ex_valid && !ex_stall) begin
                    e_br[d] = e_br[d] + 1;
                    if (tk && (tgt & mask) != 0) begin
                        e_exc[d]  = 1;
                        e_tval[d] = tgt;
                    end else begin
                        if ((tk != ex_pred_taken) || (tk && tgt != ex_pred_target)) begin
                            e_rv[d]  = 1;
                            e_rpc[d] = tk ? tgt : ex_pc + 1;
                            e_mp[d]  = e_mp[d] + 1;
                        end
                        hit = m_valid[d][idx] && (m_tag[d][idx] == tg);
                        if (ex_jal) begin
                            m_valid[d][idx] = 1; m_tag[d][idx] = tg; m_tgt[d][idx] = tgt;
                            m_ctr[d][idx] = 3;
                        end else if (ex_br && tk) begin
                            m_ctr[d][idx] = hit ? ((m_ctr[d][idx] == 3) ? 3 : m_ctr[d][idx] + 1) : 2;
                            m_valid[d][idx] = 1; m_tag[d][idx] = tg; m_tgt[d][idx] = tgt;
                        end else if (ex_br) begin
                            m_ctr[d][idx] = (m_ctr[d][idx] == 0) ? 0 : m_ctr[d][idx] - 1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: check the fetch lookup mid-cycle, then the registered results.
    task automatic step(input bit chk_pred);
        int   idx;
        bit   hit;
        logic [31:0] ep_tgt;
        @(negedge clk);
        if (chk_pred) begin
            idx = int'(f_pc % 16);
            for (int d = 0; d < 2; d++) begin
                hit    = m_valid[d][idx] && (m_tag[d][idx] == 28'(f_pc / 16));
                ep_tgt = hit ? m_tgt[d][idx] : 32'd0;
                check($sformatf("pred_taken[%0d]", d), 32'(pt[d]), 32'(hit && m_ctr[d][idx] >= 2));
                check($sformatf("pred_target[%0d]", d), ptg[d], ep_tgt);
            end
        end
        @(posedge clk);
        model_clock();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("redirect_valid[%0d]", d), 32'(rv[d]), 32'(e_rv[d]));
            check($sformatf("redirect_pc[%0d]", d), rpc[d], e_rpc[d]);
            check($sformatf("exc_misaligned[%0d]", d), 32'(exc[d]), 32'(e_exc[d]));
            check($sformatf("exc_tval[%0d]", d), tval[d], e_tval[d]);
            check($sformatf("br_count[%0d]", d), brc[d], e_br[d]);
            check($sformatf("mp_count[%0d]", d), mpc[d], e_mp[d]);
        end
    endtask

    task automatic idle();
        ex_valid = 0; ex_stall = 0; ex_br = 0; ex_jal = 0; ex_jalr = 0;
        ex_funct3 = 0; ex_pc = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_imm_b = 0; ex_imm_j = 0; ex_imm_i = 0;
        ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic pred,
                          input logic [31:0] ptgt);
        idle();
        ex_valid = 1; ex_br = 1; ex_funct3 = f3; ex_pc = pc; ex_rs1 = a; ex_rs2 = b;
        ex_imm_b = imm; ex_pred_taken = pred; ex_pred_target = ptgt;
    endtask

    logic [31:0] saved_br;

    initial begin
        idle();
        f_pc  = 32'h40;
        reset = 1;
        step(0);
        step(0);
        reset = 0;

        // Reset state
        step(1);
        check("reset_pred_taken", 32'(pt[0]), 32'd0);
        check("reset_pred_target", ptg[0], 32'd0);
        check("reset_br_count", brc[0], 32'd0);
        check("reset_mp_count", mpc[0], 32'd0);

        // BEQ taken, predicted not-taken
        branch(3'b000, 32'h10, 32'd5, 32'd5, 32'd8, 0, 32'd0);
        step(1);
        check("beq_redirect_valid", 32'(rv[0]), 32'd1);
        check("beq_redirect_pc", rpc[0], 32'h18);
        check("beq_mp_count", mpc[0], 32'd1);
        idle();
        f_pc = 32'h10;
        step(1);
        check("beq_trained_taken", 32'(pt[0]), 32'd1);
        check("beq_trained_target", ptg[0], 32'h18);

        // Signed vs unsigned compare on the same operands
        branch(3'b100, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'd4, 0, 32'd0);
        step(1);
        check("blt_redirect_pc", rpc[0], 32'h24);
        branch(3'b110, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'd4, 1, 32'h24);
        step(1);
        check("bltu_redirect_valid", 32'(rv[0]), 32'd1);
        check("bltu_redirect_pc", rpc[0], 32'h21);

        // JALR: clears bit 0, never trains; misaligned under mask 3
        idle();
        ex_valid = 1; ex_jalr = 1; ex_pc = 32'h30; ex_rs1 = 32'h101; ex_imm_i = 32'd2;
        f_pc = 32'h30;
        step(1);
        check("jalr_redirect_pc", rpc[0], 32'h102);
        check("jalr_mask3_exc", 32'(exc[1]), 32'd1);
        idle();
        step(1);
        check("jalr_no_train", 32'(pt[0]), 32'd0);

        // JAL to 0x22: misaligned under mask 3
        idle();
        ex_valid = 1; ex_jal = 1; ex_pc = 32'h12; ex_imm_j = 32'h10;
        step(1);
        check("jal_exc_misaligned", 32'(exc[1]), 32'd1);
        check("jal_exc_tval", tval[1], 32'h22);
        check("jal_no_redirect", 32'(rv[1]), 32'd0);
        idle();
        f_pc = 32'h12;
        step(1);
        check("jal_exc_no_train", 32'(pt[1]), 32'd0);
        check("jal_trained_mask0", 32'(pt[0]), 32'd1);

        // Counter saturation at 00: retrain, four not-taken, then one taken
        f_pc = 32'h10;
        branch(3'b000, 32'h10, 32'd5, 32'd5, 32'd8, 0, 32'd0);
        step(1);
        for (int i = 0; i < 4; i++) begin
            branch(3'b000, 32'h10, 32'd1, 32'd2, 32'd8, 0, 32'd0);
            step(1);
        end
        branch(3'b000, 32'h10, 32'd5, 32'd5, 32'd8, 0, 32'd0);
        step(1);
        idle();
        step(1);
        check("sat_low_pred_taken", 32'(pt[0]), 32'd0);
        check("sat_low_pred_target", ptg[0], 32'h18);

        // Stall: no resolve
        saved_br = e_br[0];
        idle();
        ex_valid = 1; ex_stall = 1; ex_jal = 1; ex_pc = 32'h50; ex_imm_j = 32'h8;
        step(1);
        check("stall_br_count", brc[0], saved_br);
        check("stall_no_pulse", 32'(rv[0]), 32'd0);

        // Reset coinciding with a mispredict resolve
        branch(3'b000, 32'h14, 32'd3, 32'd3, 32'd4, 0, 32'd0);
        reset = 1;
        step(1);
        check("reset_wins_pulse", 32'(rv[0]), 32'd0);
        check("reset_wins_mp", mpc[0], 32'd0);
        reset = 0;
        idle();
        step(1);

        // Randomized traffic with aliasing PCs
        for (int n = 0; n < 400; n++) begin
            int cls;
            idle();
            f_pc      = (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 7));
            ex_valid  = ($urandom_range(0, 7) != 0);
            ex_stall  = ($urandom_range(0, 4) == 0);
            cls       = $urandom_range(0, 5);
            ex_br     = (cls < 4);
            ex_jal    = (cls == 4);
            ex_jalr   = (cls == 5);
            ex_funct3 = 3'($urandom_range(0, 7));
            ex_pc     = (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 7));
            ex_rs1    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2)) - 32'd1;
            ex_rs2    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2)) - 32'd1;
            ex_imm_b  = 32'($urandom_range(0, 15)) - 32'd8;
            ex_imm_j  = 32'($urandom_range(0, 31)) - 32'd16;
            ex_imm_i  = 32'($urandom_range(0, 15));
            ex_pred_taken  = $urandom_range(0, 1);
            ex_pred_target = ex_pc + 32'($urandom_range(0, 3)) * 4;
            if ($urandom_range(0, 99) == 0) reset = 1;
            step(1);
            reset = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
